// File: rtl/ttl_counter_pkg.sv
// Shared definitions for the ttl_updown_counter_n family: direction constants,
// the per-edge action encoding and the saturating parallel-load helper.
package ttl_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        CNT_CLR  = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_STEP = 2'd2,
        CNT_HOLD = 2'd3
    } cnt_action_e;

    // Operands are zero-extended to 33 bits so any WIDTH up to 32 fits, including MODULUS==2**32.
    function automatic logic [32:0] sat_load(input logic [32:0] d_val, input logic [32:0] modulus);
        logic [32:0] max_val;
        max_val = modulus - 33'd1;
        if (d_val <= max_val) begin
            return d_val;
        end else begin
            return max_val;
        end
    endfunction

endpackage

// File: rtl/ttl_counter_next.sv
// Combinational next-step value and wrap flag for the modulo up/down counter.
module ttl_counter_next
    import ttl_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] q_step,
    output logic             wrap
);

    localparam logic [WIDTH:0] MOD_MAX  = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0] STEP_ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext_s;
    logic [WIDTH:0] step_s;
    logic           step_unused_s;

    // Step one position in the selected direction, wrapping inside 0..MODULUS-1.
    always_comb begin
        q_ext_s = {1'b0, q};
        step_s  = q_ext_s;
        wrap    = 1'b0;
        if (up == DIR_UP) begin
            if (q_ext_s == MOD_MAX) begin
                step_s = '0;
                wrap   = 1'b1;
            end else begin
                step_s = q_ext_s + STEP_ONE;
                wrap   = 1'b0;
            end
        end else begin
            if (q_ext_s == '0) begin
                step_s = MOD_MAX;
                wrap   = 1'b1;
            end else begin
                step_s = q_ext_s - STEP_ONE;
                wrap   = 1'b0;
            end
        end
    end

    assign q_step        = step_s[WIDTH-1:0];
    assign step_unused_s = step_s[WIDTH];

endmodule

// File: rtl/ttl_updown_counter_n.sv
// Parametrised synchronous modulo up/down counter with saturating load and cascade carry.
// Optional compare/match output enabled by defining TTL_COUNTER_MATCH_EN.
module ttl_updown_counter_n
    import ttl_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             load,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
`ifdef TTL_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] cmp,
    output logic             match,
`endif
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             tc_pulse
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ttl_updown_counter_n: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("ttl_updown_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_pulse_q, tc_pulse_d;
    logic [WIDTH-1:0] q_step_s;
    logic             term_s;
    cnt_action_e      action_s;
    logic [32:0]      d_ext_s;
    logic [32:0]      sat_full_s;
    logic [WIDTH-1:0] load_val_s;
    logic             sat_unused_s;

    ttl_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q      (q_q),
        .up     (up),
        .q_step (q_step_s),
        .wrap   (term_s)
    );

    // Out-of-range load values clamp to MODULUS-1 so q never leaves its range.
    always_comb begin
        d_ext_s      = {{(33-WIDTH){1'b0}}, d};
        sat_full_s   = sat_load(d_ext_s, 33'(MODULUS));
        load_val_s   = sat_full_s[WIDTH-1:0];
        sat_unused_s = ^sat_full_s[32:WIDTH];
    end

    // Edge priority: clear, then active-low load, then count, then hold.
    always_comb begin
        if (clr) begin
            action_s = CNT_CLR;
        end else if (!load) begin
            action_s = CNT_LOAD;
        end else if (ent && enp) begin
            action_s = CNT_STEP;
        end else begin
            action_s = CNT_HOLD;
        end
    end

    // Next count and wrap pulse for the selected action.
    always_comb begin
        q_d        = q_q;
        tc_pulse_d = 1'b0;
        case (action_s)
            CNT_CLR: begin
                q_d        = '0;
                tc_pulse_d = 1'b0;
            end
            CNT_LOAD: begin
                q_d        = load_val_s;
                tc_pulse_d = 1'b0;
            end
            CNT_STEP: begin
                q_d        = q_step_s;
                tc_pulse_d = term_s;
            end
            CNT_HOLD: begin
                q_d        = q_q;
                tc_pulse_d = 1'b0;
            end
            default: begin
                q_d        = q_q;
                tc_pulse_d = 1'b0;
            end
        endcase
    end

    // Count and pulse registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clr) begin
            q_q        <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

`ifdef TTL_COUNTER_MATCH_EN
    logic match_q, match_d;

    // q_d is always in range, so a cmp at or above MODULUS can never match.
    always_comb begin
        match_d = (q_d == cmp);
    end

    // Match register compares against the value q takes at this edge.
    always_ff @(posedge clock) begin
        if (clr) begin
            match_q <= (cmp == '0);
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign q        = q_q;
    assign tc_pulse = tc_pulse_q;
    assign rco      = ent & term_s;

endmodule

// File: tb/tb_ttl_updown_counter_n.sv
// Directed self-checking bench: modulo-10 counter plus a two-stage modulo-16 cascade.
module tb_ttl_updown_counter_n;

    logic       clock = 1'b0;
    logic       clr, load, ent, enp, up;
    logic [3:0] d, q;
    logic       rco, tc_pulse;

    logic       c_clr, c_load, c_enp, c_up;
    logic [3:0] c_d_lo, c_d_hi, q_lo, q_hi;
    logic       rco_lo, rco_hi, tc_lo, tc_hi;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q;
    int exp_c;

`ifdef TTL_COUNTER_MATCH_EN
    logic [3:0] cmp;
    logic       match;
    logic       match_lo, match_hi;
`endif

    always #5 clock = ~clock;

    ttl_updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
        .clock    (clock),
        .clr      (clr),
        .load     (load),
        .ent      (ent),
        .enp      (enp),
        .up       (up),
        .d        (d),
`ifdef TTL_COUNTER_MATCH_EN
        .cmp      (cmp),
        .match    (match),
`endif
        .q        (q),
        .rco      (rco),
        .tc_pulse (tc_pulse)
    );

    ttl_updown_counter_n #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clock    (clock),
        .clr      (c_clr),
        .load     (c_load),
        .ent      (1'b1),
        .enp      (c_enp),
        .up       (c_up),
        .d        (c_d_lo),
`ifdef TTL_COUNTER_MATCH_EN
        .cmp      (4'd0),
        .match    (match_lo),
`endif
        .q        (q_lo),
        .rco      (rco_lo),
        .tc_pulse (tc_lo)
    );

    ttl_updown_counter_n #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clock    (clock),
        .clr      (c_clr),
        .load     (c_load),
        .ent      (rco_lo),
        .enp      (c_enp),
        .up       (c_up),
        .d        (c_d_hi),
`ifdef TTL_COUNTER_MATCH_EN
        .cmp      (4'd0),
        .match    (match_hi),
`endif
        .q        (q_hi),
        .rco      (rco_hi),
        .tc_pulse (tc_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clr = 1'b1; load = 1'b1; ent = 1'b1; enp = 1'b0; up = 1'b1; d = 4'd0;
        c_clr = 1'b1; c_load = 1'b1; c_enp = 1'b0; c_up = 1'b1; c_d_lo = 4'd0; c_d_hi = 4'd0;
`ifdef TTL_COUNTER_MATCH_EN
        cmp = 4'd0;
`endif
        tick();
        check("reset_q", 32'(q), 32'd0);
        check("reset_tc", 32'(tc_pulse), 32'd0);
        check("reset_rco_up", 32'(rco), 32'd0);
        up = 1'b0;
        #1;
        check("reset_rco_down", 32'(rco), 32'd1);

        // Up count from 0 through 9 and wrap to 0.
        clr = 1'b0; up = 1'b1; enp = 1'b1; exp_q = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("up_rco", 32'(rco), 32'(exp_q == 9));
            tick();
            exp_q = (exp_q + 1) % 10;
            check("up_q", 32'(q), 32'(exp_q));
            check("up_tc", 32'(tc_pulse), 32'(exp_q == 0));
        end
        tick();
        exp_q = 1;
        check("up_after_q", 32'(q), 32'(exp_q));
        check("up_after_tc", 32'(tc_pulse), 32'd0);

        // Load 3, count down through the wrap to 9.
        load = 1'b0; d = 4'd3; up = 1'b0;
        tick();
        exp_q = 3;
        check("load3_q", 32'(q), 32'd3);
        check("load3_tc", 32'(tc_pulse), 32'd0);
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dn_rco", 32'(rco), 32'(exp_q == 0));
            tick();
            exp_q = (exp_q == 0) ? 9 : exp_q - 1;
            check("dn_q", 32'(q), 32'(exp_q));
            check("dn_tc", 32'(tc_pulse), 32'(exp_q == 9));
        end
        load = 1'b0; d = 4'd12;
        tick();
        check("load_sat_q", 32'(q), 32'd9);
        check("load_sat_tc", 32'(tc_pulse), 32'd0);
        load = 1'b1;

        // enp low holds the count while rco still follows ent.
        up = 1'b1; enp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", 32'(q), 32'd9);
            check("hold_rco", 32'(rco), 32'd1);
            check("hold_tc", 32'(tc_pulse), 32'd0);
        end
        enp = 1'b1;
        tick();
        check("release_q", 32'(q), 32'd0);
        check("release_tc", 32'(tc_pulse), 32'd1);

        // clr beats a simultaneous load; mid-count clr restarts from 0.
        load = 1'b0; d = 4'd7;
        tick();
        check("load7_q", 32'(q), 32'd7);
        clr = 1'b1; load = 1'b0; d = 4'd5;
        tick();
        check("clr_vs_load_q", 32'(q), 32'd0);
        check("clr_vs_load_tc", 32'(tc_pulse), 32'd0);
        clr = 1'b0; load = 1'b1; enp = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("pre_clr_q", 32'(q), 32'd4);
        clr = 1'b1;
        tick();
        check("mid_clr_q", 32'(q), 32'd0);
        clr = 1'b0;
        tick();
        check("resume1_q", 32'(q), 32'd1);
        tick();
        check("resume2_q", 32'(q), 32'd2);

`ifdef TTL_COUNTER_MATCH_EN
        // match tracks q==cmp in the same cycle, both directions.
        cmp = 4'd6; clr = 1'b1;
        tick();
        check("match_clr", 32'(match), 32'd0);
        clr = 1'b0; up = 1'b1; exp_q = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_q = (exp_q + 1) % 10;
            check("match_up", 32'(match), 32'(exp_q == 6));
        end
        up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_q = (exp_q == 0) ? 9 : exp_q - 1;
            check("match_dn", 32'(match), 32'(exp_q == 6));
        end
        cmp = 4'd0; clr = 1'b1;
        tick();
        check("match_clr_zero", 32'(match), 32'd1);
        cmp = 4'd11; clr = 1'b0; up = 1'b1;
        tick();
        check("match_oor_first", 32'(match), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("match_oor", 32'(match), 32'd0);
        end
`endif

        // Cascade: 8-bit count through 0xFF back to 0x00.
        c_clr = 1'b0; c_enp = 1'b1; c_up = 1'b1; exp_c = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            check("casc_rco_hi", 32'(rco_hi), 32'(exp_c == 255));
            tick();
            exp_c = (exp_c + 1) % 256;
            check("casc_q", 32'({q_hi, q_lo}), 32'(exp_c));
            check("casc_tc_hi", 32'(tc_hi), 32'(exp_c == 0));
        end
        c_load = 1'b0; c_d_lo = 4'd0; c_d_hi = 4'd1;
        tick();
        check("casc_load", 32'({q_hi, q_lo}), 32'h10);
        c_load = 1'b1; c_up = 1'b0;
        tick();
        check("casc_borrow", 32'({q_hi, q_lo}), 32'h0F);
        check("casc_borrow_tc_lo", 32'(tc_lo), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ttl_updown_counter_n.md
Name: ttl_updown_counter_n

Overview:
Parametrised synchronous up/down counter with parallel load, dual count enables and a cascade carry. It is the generalised successor of the 4-bit 74-series counter blocks, with configurable width, configurable modulus and a direction input. It sits in datapath and sequencing logic, such as the program counter, step counters and cascaded timers. Several instances cascade through rco into ent.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error outside that range

Ports:
clock  input  1  single clock; all state changes on its rising edge
clr  input  1  reset, synchronous, active-high; clears counter state
load  input  1  active-low synchronous parallel load
ent  input  1  count enable, also gates rco (cascade carry in)
enp  input  1  count enable (general)
up  input  1  direction: 1 counts up, 0 counts down
d  input  WIDTH  parallel load value
q  output  WIDTH  current count
rco  output  1  ripple carry/borrow out (combinational)
tc_pulse  output  1  registered one-cycle pulse following a wrap

Behaviour:
- Priority at each rising clock edge: clr, then load==0, then count (ent&enp), then hold.
- clr=1: q<=0 and tc_pulse<=0. This is synchronous only; asserting clr between edges has no effect until the next edge. It overrides load/count in the same cycle.
- load==0:
  - q<=d when d<=MODULUS-1.
  - q<=MODULUS-1 when d>MODULUS-1 (saturating load, so q is never out of range).
  - Load ignores ent/enp/up. tc_pulse<=0.
- Count with up=1: q<=q+1; when q==MODULUS-1, q<=0 (wrap).
- Count with up=0: q<=q-1; when q==0, q<=MODULUS-1 (wrap).
- Hold (ent&enp==0, load==1, clr==0): q unchanged; tc_pulse<=0.
- Terminal condition term = up ? (q==MODULUS-1) : (q==0).
- rco = ent & term. It is combinational, enp does not gate it, and it has zero latency for cascading.
- tc_pulse:
  - Set to 1 for exactly one cycle after an edge where a counting step wrapped (term & ent & enp).
  - Otherwise 0.
  - Latency is 1 cycle relative to the wrapping edge.
- Direction change takes effect on the next counting edge; there is no pipeline.
- MODULUS==2**WIDTH: wrap is natural overflow; behaviour is identical to the rules above.
- Reset values: q=0, tc_pulse=0; rco=ent&(up?0==MODULUS-1:1), i.e. rco=ent when up=0.
- All arithmetic is done at WIDTH+1 bits internally; no result escapes the range 0..MODULUS-1.

Optional Feature:
Macro TTL_COUNTER_MATCH_EN.
- Defined:
  - Adds input cmp [WIDTH] and output match [1].
  - match is registered: match<=(next q==cmp) at every edge, so it is valid in the same cycle q takes the value.
  - Reset value of match is (cmp==0) sampled at the clr edge.
  - cmp>=MODULUS never matches.
- Not defined: no cmp/match ports and no comparator logic; all other behaviour is identical.

Decomposition:
- Shared package ttl_counter_pkg:
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0;
  - typedef for the action encoding CNT_CLR/CNT_LOAD/CNT_STEP/CNT_HOLD;
  - a function computing the saturated load value.
- One combinational sub-module, ttl_counter_next:
  - inputs q, up, MODULUS;
  - outputs next-step value and wrap flag.
- The top module holds the registers, priority logic, rco and tc_pulse.

Test Plan:
- WIDTH=4, MODULUS=10, up=1, ent=enp=1 from reset: q steps 0..9 then 0; rco=1 only while q==9; tc_pulse=1 in the cycle q==0 after the wrap.
- Same config, up=0, load d=3 then count: q 3,2,1,0,9; rco=1 only at q==0; load d=12 gives q=9 (saturation).
- ent=1, enp=0 for 5 cycles at q==9, up=1: q holds 9, rco stays 1, tc_pulse stays 0; raising enp gives q=0 next edge.
- clr=1 with load=0 and d=5 asserted together at q=7: q=0 next edge; clr pulsed mid-count (q=4) gives q=0, then counting resumes 1,2,...
- Two instances, WIDTH=4, MODULUS=16, rco0 to ent1, common enp: the pair counts 0x00..0xFF and wraps to 0x00; the upper nibble increments only when the lower wraps; a down-count borrow from 0x10 gives 0x0F.
- With TTL_COUNTER_MATCH_EN and cmp=6: match=1 exactly in the cycle q==6, up and down; cmp=11 with MODULUS=10 never matches.
